// File: rtl/wbi_arb_seq_if.sv
`default_nettype none
// ============================================================================
// wbi_arb_seq_if
// Requester-side and downstream-side signal bundle for the wbi_arb_seq
// arbiter. The slave modport is the arbiter's view; master is the view of
// the requesters and downstream chain that surround it.
// Rev 1.0 - initial release
// ============================================================================
interface wbi_arb_seq_if #(
    parameter int NM = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
);
    logic [NM-1:0]    m_cmd_wval_i;
    logic [NM-1:0]    m_cmd_wrdy_o;
    logic [NM*AW-1:0] m_cmd_adr_i;
    logic [NM-1:0]    m_cmd_we_i;
    logic [NM*DW-1:0] m_cmd_dat_i;
    logic [NM*BW-1:0] m_cmd_sel_i;
    logic [NM*4-1:0]  m_cmd_tid_i;
    logic [NM*BL-1:0] m_cmd_bl_i;
    logic [NM-1:0]    m_res_rrdy_i;
    logic [NM-1:0]    m_res_rval_o;
    logic [DW-1:0]    m_res_dat_o;
    logic             m_res_ack_o;
    logic             m_res_lack_o;
    logic             m_res_err_o;
    logic [3:0]       m_res_tid_o;

    logic             wbd_cmd_wrdy_i;
    logic             wbd_cmd_wval_o;
    logic [AW-1:0]    wbd_cmd_adr_o;
    logic             wbd_cmd_we_o;
    logic [DW-1:0]    wbd_cmd_dat_o;
    logic [BW-1:0]    wbd_cmd_sel_o;
    logic [3:0]       wbd_cmd_tid_o;
    logic [BL-1:0]    wbd_cmd_bl_o;
    logic             wbd_res_rrdy_o;
    logic             wbd_res_rval_i;
    logic [DW-1:0]    wbd_res_dat_i;
    logic             wbd_res_ack_i;
    logic             wbd_res_lack_i;
    logic             wbd_res_err_i;
    logic [3:0]       wbd_res_tid_i;

    modport slave (
        input  m_cmd_wval_i, m_cmd_adr_i, m_cmd_we_i, m_cmd_dat_i, m_cmd_sel_i,
               m_cmd_tid_i, m_cmd_bl_i, m_res_rrdy_i,
        output m_cmd_wrdy_o, m_res_rval_o, m_res_dat_o, m_res_ack_o,
               m_res_lack_o, m_res_err_o, m_res_tid_o,
        input  wbd_cmd_wrdy_i, wbd_res_rval_i, wbd_res_dat_i, wbd_res_ack_i,
               wbd_res_lack_i, wbd_res_err_i, wbd_res_tid_i,
        output wbd_cmd_wval_o, wbd_cmd_adr_o, wbd_cmd_we_o, wbd_cmd_dat_o,
               wbd_cmd_sel_o, wbd_cmd_tid_o, wbd_cmd_bl_o, wbd_res_rrdy_o
    );

    modport master (
        output m_cmd_wval_i, m_cmd_adr_i, m_cmd_we_i, m_cmd_dat_i, m_cmd_sel_i,
               m_cmd_tid_i, m_cmd_bl_i, m_res_rrdy_i,
        input  m_cmd_wrdy_o, m_res_rval_o, m_res_dat_o, m_res_ack_o,
               m_res_lack_o, m_res_err_o, m_res_tid_o,
        output wbd_cmd_wrdy_i, wbd_res_rval_i, wbd_res_dat_i, wbd_res_ack_i,
               wbd_res_lack_i, wbd_res_err_i, wbd_res_tid_i,
        input  wbd_cmd_wval_o, wbd_cmd_adr_o, wbd_cmd_we_o, wbd_cmd_dat_o,
               wbd_cmd_sel_o, wbd_cmd_tid_o, wbd_cmd_bl_o, wbd_res_rrdy_o
    );
endinterface
`default_nettype wire

// File: rtl/wbi_arb_seq.sv
`default_nettype none
// ============================================================================
// wbi_arb_seq
// Round-robin arbiter/sequencer: one outstanding transaction to a shared
// downstream port, responses routed back to the granted requester, timeout.
// Rev 1.0 - initial release
// ============================================================================
module wbi_arb_seq #(
    parameter int NM  = 4,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BW  = 4,
    parameter int BL  = 10,
    parameter int TMO = 1024
) (
    input  wire logic    mclk,
    input  wire logic    reset_n,
    wbi_arb_seq_if.slave bus,
    output logic [2:0]   grant_o,
    output logic         busy_o,
    output logic         tmo_o,
    output logic         drop_o
);
    localparam int          IW       = (NM > 1) ? $clog2(NM) : 1;
    localparam bit          TMO_EN   = (TMO != 0);
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RESP = 2'd2,
        S_TERR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [15:0]   timer_q, timer_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [BW-1:0] sel_q, sel_d;
    logic [3:0]    tid_q, tid_d;
    logic [BL-1:0] bl_q, bl_d;
    logic          tmo_q, tmo_d;
    logic          drop_q, drop_d;

    logic [AW-1:0] w_adr [NM];
    logic [DW-1:0] w_dat [NM];
    logic [BW-1:0] w_sel [NM];
    logic [3:0]    w_tid [NM];
    logic [BL-1:0] w_bl  [NM];

    logic          w_win_vld;
    logic [IW-1:0] w_win_sel;
    logic [IW-1:0] w_ptr_nxt;
    logic [NM-1:0] w_cmd_wrdy;
    logic [NM-1:0] w_res_rval;
    logic          w_res_rrdy;
    logic [DW-1:0] w_res_dat;
    logic          w_res_ack;
    logic          w_res_lack;
    logic          w_res_err;
    logic [3:0]    w_res_tid;

    for (genvar k = 0; k < NM; k++) begin : g_req
        assign w_adr[k] = bus.m_cmd_adr_i[k*AW +: AW];
        assign w_dat[k] = bus.m_cmd_dat_i[k*DW +: DW];
        assign w_sel[k] = bus.m_cmd_sel_i[k*BW +: BW];
        assign w_tid[k] = bus.m_cmd_tid_i[k*4 +: 4];
        assign w_bl[k]  = bus.m_cmd_bl_i[k*BL +: BL];
    end

    // First requesting index at or after rr_ptr, wrapping modulo NM.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_sel = '0;
        for (int k = 0; k < NM; k++) begin
            int unsigned idx;
            idx = (int'(rr_ptr_q) + k) % NM;
            if (!w_win_vld && bus.m_cmd_wval_i[IW'(idx)]) begin
                w_win_vld = 1'b1;
                w_win_sel = IW'(idx);
            end
        end
    end

    assign w_ptr_nxt = (grant_q == IW'(NM - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        adr_d      = adr_q;
        we_d       = we_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        tid_d      = tid_q;
        bl_d       = bl_q;
        tmo_d      = tmo_q;
        drop_d     = drop_q;
        w_cmd_wrdy = '0;
        w_res_rval = '0;
        w_res_rrdy = 1'b0;
        w_res_dat  = bus.wbd_res_dat_i;
        w_res_ack  = bus.wbd_res_ack_i;
        w_res_lack = bus.wbd_res_lack_i;
        w_res_err  = bus.wbd_res_err_i;
        w_res_tid  = bus.wbd_res_tid_i;
        unique case (state_q)
            S_IDLE: begin
                w_res_rrdy = 1'b1;
                if (bus.wbd_res_rval_i) drop_d = 1'b1;
                if (w_win_vld) begin
                    w_cmd_wrdy[w_win_sel] = 1'b1;
                    adr_d   = w_adr[w_win_sel];
                    we_d    = bus.m_cmd_we_i[w_win_sel];
                    dat_d   = w_dat[w_win_sel];
                    sel_d   = w_sel[w_win_sel];
                    tid_d   = w_tid[w_win_sel];
                    bl_d    = w_bl[w_win_sel];
                    grant_d = w_win_sel;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                w_res_rrdy = 1'b1;
                if (bus.wbd_res_rval_i) drop_d = 1'b1;
                if (bus.wbd_cmd_wrdy_i) begin
                    state_d = S_RESP;
                    timer_d = '0;
                end
            end
            S_RESP: begin
                w_res_rval[grant_q] = bus.wbd_res_rval_i;
                w_res_rrdy          = bus.m_res_rrdy_i[grant_q];
                if (bus.wbd_res_rval_i && bus.m_res_rrdy_i[grant_q]) begin
                    if (bus.wbd_res_lack_i || bus.wbd_res_err_i) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = w_ptr_nxt;
                    end else begin
                        timer_d = '0;
                    end
                end else begin
                    if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
                    if (TMO_EN && timer_q == TMO_LAST) begin
                        state_d = S_TERR;
                        tmo_d   = 1'b1;
                    end
                end
            end
            S_TERR: begin
                // Synthesized error beat; the downstream chain is held off.
                w_res_rval[grant_q] = 1'b1;
                w_res_dat           = '0;
                w_res_ack           = 1'b0;
                w_res_lack          = 1'b1;
                w_res_err           = 1'b1;
                w_res_tid           = tid_q;
                if (bus.m_res_rrdy_i[grant_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = w_ptr_nxt;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            timer_q  <= '0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            tid_q    <= '0;
            bl_q     <= '0;
            tmo_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            tid_q    <= tid_d;
            bl_q     <= bl_d;
            tmo_q    <= tmo_d;
            drop_q   <= drop_d;
        end
    end

    // The accept strobe is combinational from IDLE, so mask it while reset is held.
    assign bus.m_cmd_wrdy_o   = reset_n ? w_cmd_wrdy : '0;
    assign bus.m_res_rval_o   = w_res_rval;
    assign bus.m_res_dat_o    = w_res_dat;
    assign bus.m_res_ack_o    = w_res_ack;
    assign bus.m_res_lack_o   = w_res_lack;
    assign bus.m_res_err_o    = w_res_err;
    assign bus.m_res_tid_o    = w_res_tid;
    assign bus.wbd_res_rrdy_o = w_res_rrdy;
    assign bus.wbd_cmd_wval_o = (state_q == S_CMD);
    assign bus.wbd_cmd_adr_o  = adr_q;
    assign bus.wbd_cmd_we_o   = we_q;
    assign bus.wbd_cmd_dat_o  = dat_q;
    assign bus.wbd_cmd_sel_o  = sel_q;
    assign bus.wbd_cmd_tid_o  = tid_q;
    assign bus.wbd_cmd_bl_o   = bl_q;
    assign grant_o            = 3'(grant_q);
    assign busy_o             = (state_q != S_IDLE);
    assign tmo_o              = tmo_q;
    assign drop_o             = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_wbi_arb_seq.sv
`default_nettype none
// ============================================================================
// tb_wbi_arb_seq
// Directed scenarios plus randomized traffic against a transaction-level model.
// Rev 1.0 - initial release
// ============================================================================
module tb_wbi_arb_seq;
    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int BL  = 10;
    localparam int TMO = 16;

    logic       mclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] grant;
    logic       busy, tmo, drop;

    int nvec = 0;
    int nerr = 0;

    wbi_arb_seq_if #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL)) bus ();

    wbi_arb_seq #(.NM(NM), .AW(AW), .DW(DW), .BW(BW), .BL(BL), .TMO(TMO)) u_dut (
        .mclk    (mclk),
        .reset_n (reset_n),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy),
        .tmo_o   (tmo),
        .drop_o  (drop)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // phase: 0 waiting for a request, 1 command offered, 2 collecting beats,
    // 3 delivering the synthesized timeout error
    int            mph, mg, mptr, mwait;
    bit            mtmo, mdrop;
    logic [AW-1:0] m_adr;
    logic          m_we;
    logic [DW-1:0] m_dat;
    logic [BW-1:0] m_sel;
    logic [3:0]    m_tid;
    logic [BL-1:0] m_bl;

    always @(negedge mclk) begin : cmp
        logic [NM-1:0] e_wrdy, e_rval;
        logic          e_rrdy;
        int            w;
        if (!reset_n) begin
            mph = 0; mg = 0; mptr = 0; mwait = 0; mtmo = 0; mdrop = 0;
            m_adr = '0; m_we = 0; m_dat = '0; m_sel = '0; m_tid = '0; m_bl = '0;
            chk("rst_wrdy", bus.m_cmd_wrdy_o, 0);
            chk("rst_wval", bus.wbd_cmd_wval_o, 0);
            chk("rst_rval", bus.m_res_rval_o, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant, 0);
            chk("rst_flags", {tmo, drop}, 0);
        end else begin
            w = -1;
            e_wrdy = '0;
            e_rval = '0;
            e_rrdy = 1'b1;
            if (mph == 0)
                for (int k = 0; k < NM; k++)
                    if (w < 0 && bus.m_cmd_wval_i[(mptr + k) % NM]) w = (mptr + k) % NM;
            if (w >= 0) e_wrdy[w] = 1'b1;
            if (mph == 2) begin
                e_rval[mg] = bus.wbd_res_rval_i;
                e_rrdy     = bus.m_res_rrdy_i[mg];
            end else if (mph == 3) begin
                e_rval[mg] = 1'b1;
                e_rrdy     = 1'b0;
            end
            chk("m_wrdy", bus.m_cmd_wrdy_o, e_wrdy);
            chk("m_rval", bus.m_res_rval_o, e_rval);
            chk("d_rrdy", bus.wbd_res_rrdy_o, e_rrdy);
            chk("d_wval", bus.wbd_cmd_wval_o, mph == 1);
            chk("d_adr", bus.wbd_cmd_adr_o, m_adr);
            chk("d_dat", bus.wbd_cmd_dat_o, m_dat);
            chk("d_misc", {bus.wbd_cmd_we_o, bus.wbd_cmd_sel_o, bus.wbd_cmd_tid_o, bus.wbd_cmd_bl_o},
                {m_we, m_sel, m_tid, m_bl});
            chk("grant", grant, mg);
            chk("busy", busy, mph != 0);
            chk("tmo", tmo, mtmo);
            chk("drop", drop, mdrop);
            if (e_rval != 0) begin
                if (mph == 2)
                    chk("res_pass", {bus.m_res_dat_o, bus.m_res_ack_o, bus.m_res_lack_o, bus.m_res_err_o, bus.m_res_tid_o},
                        {bus.wbd_res_dat_i, bus.wbd_res_ack_i, bus.wbd_res_lack_i, bus.wbd_res_err_i, bus.wbd_res_tid_i});
                else
                    chk("res_terr", {bus.m_res_dat_o, bus.m_res_ack_o, bus.m_res_lack_o, bus.m_res_err_o, bus.m_res_tid_o},
                        {32'h0, 1'b0, 1'b1, 1'b1, m_tid});
            end
            case (mph)
                0: begin
                    if (bus.wbd_res_rval_i) mdrop = 1;
                    if (w >= 0) begin
                        m_adr = bus.m_cmd_adr_i[w*AW +: AW];
                        m_we  = bus.m_cmd_we_i[w];
                        m_dat = bus.m_cmd_dat_i[w*DW +: DW];
                        m_sel = bus.m_cmd_sel_i[w*BW +: BW];
                        m_tid = bus.m_cmd_tid_i[w*4 +: 4];
                        m_bl  = bus.m_cmd_bl_i[w*BL +: BL];
                        mg    = w;
                        mph   = 1;
                    end
                end
                1: begin
                    if (bus.wbd_res_rval_i) mdrop = 1;
                    if (bus.wbd_cmd_wrdy_i) begin mph = 2; mwait = 0; end
                end
                2: begin
                    if (bus.wbd_res_rval_i && bus.m_res_rrdy_i[mg]) begin
                        if (bus.wbd_res_lack_i || bus.wbd_res_err_i) begin
                            mph = 0; mptr = (mg + 1) % NM;
                        end else mwait = 0;
                    end else begin
                        // TMO consecutive cycles without an accepted beat
                        mwait++;
                        if (TMO != 0 && mwait == TMO) begin mph = 3; mtmo = 1; end
                    end
                end
                default: if (bus.m_res_rrdy_i[mg]) begin mph = 0; mptr = (mg + 1) % NM; end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cmd_wval_i = '0; bus.m_cmd_adr_i = '0; bus.m_cmd_we_i = '0;
        bus.m_cmd_dat_i = '0; bus.m_cmd_sel_i = '0; bus.m_cmd_tid_i = '0;
        bus.m_cmd_bl_i = '0; bus.m_res_rrdy_i = '0;
        bus.wbd_cmd_wrdy_i = 0; bus.wbd_res_rval_i = 0; bus.wbd_res_dat_i = '0;
        bus.wbd_res_ack_i = 0; bus.wbd_res_lack_i = 0; bus.wbd_res_err_i = 0;
        bus.wbd_res_tid_i = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge mclk);
        #1 reset_n = 1'b1;
    endtask

    task automatic set_req(input int k, input logic [31:0] adr, input logic [3:0] tid, input logic [9:0] bl);
        bus.m_cmd_adr_i[k*AW +: AW] = adr;
        bus.m_cmd_we_i[k]           = 1'b0;
        bus.m_cmd_dat_i[k*DW +: DW] = 32'h1111_0000 + k;
        bus.m_cmd_sel_i[k*BW +: BW] = 4'hF;
        bus.m_cmd_tid_i[k*4 +: 4]   = tid;
        bus.m_cmd_bl_i[k*BL +: BL]  = bl;
    endtask

    task automatic rand_cycle(input int pv, input int pw, input int pr);
        for (int k = 0; k < NM; k++) begin
            bus.m_cmd_wval_i[k] = ($urandom_range(0, 99) < pv);
            bus.m_res_rrdy_i[k] = ($urandom_range(0, 99) < 60);
        end
        bus.m_cmd_adr_i    = {$urandom, $urandom, $urandom, $urandom};
        bus.m_cmd_dat_i    = {$urandom, $urandom, $urandom, $urandom};
        bus.m_cmd_we_i     = 4'($urandom);
        bus.m_cmd_sel_i    = 16'($urandom);
        bus.m_cmd_tid_i    = 16'($urandom);
        bus.m_cmd_bl_i     = {$urandom, 8'($urandom)};
        bus.wbd_cmd_wrdy_i = ($urandom_range(0, 99) < pw);
        bus.wbd_res_rval_i = ($urandom_range(0, 99) < pr);
        bus.wbd_res_dat_i  = $urandom;
        bus.wbd_res_ack_i  = 1'($urandom);
        bus.wbd_res_lack_i = ($urandom_range(0, 99) < 35);
        bus.wbd_res_err_i  = ($urandom_range(0, 99) < 5);
        bus.wbd_res_tid_i  = 4'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    logic [NM-1:0] got [5];
    int            ng, beat;
    bit            tog;

    initial begin
        clear_inputs();

        // 1: single read from requester 1, downstream stalls 3 cycles
        do_reset();
        set_req(1, 32'h1000, 4'd5, 10'd1);
        bus.m_cmd_wval_i = 4'b0010;
        @(negedge mclk);
        chk("t1_wrdy", bus.m_cmd_wrdy_o, 4'b0010);
        chk("t1_busy0", busy, 0);
        tick();
        bus.m_cmd_wval_i = '0;
        @(negedge mclk);
        chk("t1_wval", bus.wbd_cmd_wval_o, 1);
        chk("t1_adr", bus.wbd_cmd_adr_o, 32'h1000);
        chk("t1_tid", bus.wbd_cmd_tid_o, 5);
        chk("t1_grant", grant, 1);
        repeat (2) begin
            tick();
            @(negedge mclk);
            chk("t1_hold", bus.wbd_cmd_wval_o, 1);
        end
        tick();
        bus.wbd_cmd_wrdy_i = 1;
        @(negedge mclk);
        tick();
        bus.wbd_cmd_wrdy_i = 0;
        bus.wbd_res_rval_i = 1; bus.wbd_res_dat_i = 32'hA5A5A5A5;
        bus.wbd_res_lack_i = 1; bus.wbd_res_ack_i = 1; bus.wbd_res_tid_i = 4'd5;
        bus.m_res_rrdy_i = 4'b0010;
        @(negedge mclk);
        chk("t1_rval", bus.m_res_rval_o, 4'b0010);
        chk("t1_rdat", bus.m_res_dat_o, 32'hA5A5A5A5);
        tick();
        clear_inputs();
        bus.m_cmd_wval_i = 4'b1111;
        @(negedge mclk);
        chk("t1_idle", busy, 0);
        chk("t1_ptr2", bus.m_cmd_wrdy_o, 4'b0100);
        tick();

        // 2: all requesters busy, one-beat transactions
        do_reset();
        bus.m_cmd_wval_i = 4'b1111; bus.wbd_cmd_wrdy_i = 1; bus.m_res_rrdy_i = 4'b1111;
        bus.wbd_res_rval_i = 1; bus.wbd_res_lack_i = 1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge mclk);
            if (bus.m_cmd_wrdy_o != 0) begin got[ng] = bus.m_cmd_wrdy_o; ng++; end
            tick();
        end
        chk("t2_count", ng, 5);
        chk("t2_g0", got[0], 4'b0001);
        chk("t2_g1", got[1], 4'b0010);
        chk("t2_g2", got[2], 4'b0100);
        chk("t2_g3", got[3], 4'b1000);
        chk("t2_g4", got[4], 4'b0001);

        // 3: 4-beat burst from requester 2 with a toggling ready
        do_reset();
        set_req(2, 32'h2200, 4'd9, 10'd4);
        bus.m_cmd_wval_i = 4'b0100;
        @(negedge mclk);
        chk("t3_wrdy", bus.m_cmd_wrdy_o, 4'b0100);
        tick();
        bus.m_cmd_wval_i = 4'b0001; bus.wbd_cmd_wrdy_i = 1;
        @(negedge mclk);
        chk("t3_bl", bus.wbd_cmd_bl_o, 4);
        tick();
        bus.wbd_cmd_wrdy_i = 0;
        beat = 0; tog = 1;
        for (int c = 0; c < 30 && beat < 4; c++) begin
            bus.wbd_res_rval_i = 1; bus.wbd_res_lack_i = (beat == 3);
            bus.wbd_res_dat_i = 32'hB000_0000 + beat; bus.wbd_res_ack_i = 1;
            bus.m_res_rrdy_i = tog ? 4'b0100 : 4'b0000;
            @(negedge mclk);
            chk("t3_nogrant", bus.m_cmd_wrdy_o, 0);
            chk("t3_rval", bus.m_res_rval_o, 4'b0100);
            if (tog) begin
                chk("t3_lack", bus.m_res_lack_o, beat == 3);
                beat++;
            end
            tog = !tog;
            tick();
        end
        bus.wbd_res_rval_i = 0;
        chk("t3_beats", beat, 4);
        @(negedge mclk);
        chk("t3_done", busy, 0);
        chk("t3_next", bus.m_cmd_wrdy_o, 4'b0001);
        chk("t3_nodrop", drop, 0);
        tick();

        // 4: timeout on requester 3, then a late beat is drained
        do_reset();
        set_req(3, 32'h3300, 4'hC, 10'd1);
        bus.m_cmd_wval_i = 4'b1000;
        @(negedge mclk);
        chk("t4_wrdy", bus.m_cmd_wrdy_o, 4'b1000);
        tick();
        bus.m_cmd_wval_i = '0; bus.wbd_cmd_wrdy_i = 1;
        @(negedge mclk);
        tick();
        bus.wbd_cmd_wrdy_i = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge mclk);
            chk("t4_wait", {bus.m_res_rval_o, tmo}, 0);
            tick();
        end
        @(negedge mclk);
        chk("t4_rval", bus.m_res_rval_o, 4'b1000);
        chk("t4_fields", {bus.m_res_dat_o, bus.m_res_ack_o, bus.m_res_lack_o, bus.m_res_err_o, bus.m_res_tid_o},
            {32'h0, 1'b0, 1'b1, 1'b1, 4'hC});
        chk("t4_tmo", tmo, 1);
        chk("t4_drrdy", bus.wbd_res_rrdy_o, 0);
        tick();
        bus.m_res_rrdy_i = 4'b1000;
        @(negedge mclk);
        tick();
        bus.m_res_rrdy_i = '0; bus.wbd_res_rval_i = 1;
        @(negedge mclk);
        chk("t4_idle", busy, 0);
        chk("t4_drop0", drop, 0);
        tick();
        bus.wbd_res_rval_i = 0;
        @(negedge mclk);
        chk("t4_drop1", drop, 1);
        tick();

        // 5: error beat mid-burst, then reset while in CMD
        do_reset();
        set_req(1, 32'h2000, 4'd3, 10'd4);
        bus.m_cmd_wval_i = 4'b0010;
        @(negedge mclk);
        tick();
        bus.m_cmd_wval_i = '0; bus.wbd_cmd_wrdy_i = 1;
        @(negedge mclk);
        tick();
        bus.wbd_cmd_wrdy_i = 0; bus.wbd_res_rval_i = 1; bus.m_res_rrdy_i = 4'b0010;
        @(negedge mclk);
        chk("t5_beat1", bus.m_res_rval_o, 4'b0010);
        tick();
        bus.wbd_res_err_i = 1;
        @(negedge mclk);
        chk("t5_err", bus.m_res_err_o, 1);
        tick();
        bus.wbd_res_rval_i = 0; bus.wbd_res_err_i = 0; bus.m_res_rrdy_i = '0;
        @(negedge mclk);
        chk("t5_ended", busy, 0);
        tick();
        bus.m_cmd_wval_i = 4'b0010;
        @(negedge mclk);
        tick();
        bus.m_cmd_wval_i = '0;
        @(negedge mclk);
        chk("t5_incmd", grant, 1);
        @(posedge mclk);
        #3;
        bus.m_cmd_wval_i = 4'b1111;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_wval", bus.wbd_cmd_wval_o, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_adr", bus.wbd_cmd_adr_o, 0);
        chk("t5_rst_wrdy", bus.m_cmd_wrdy_o, 0);
        repeat (2) @(posedge mclk);
        #1;
        reset_n = 1'b1;
        bus.m_cmd_wval_i = '0;
        @(negedge mclk);
        chk("t5_post_busy", busy, 0);
        tick();

        // randomized traffic against the model
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            int pr;
            case (blk % 3)
                0:       pr = 80;
                1:       pr = 30;
                default: pr = 3;
            endcase
            for (int c = 0; c < 250; c++) begin
                rand_cycle(40, 50, pr);
                tick();
            end
        end
        clear_inputs();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
